// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the one-hot ALU: decodes RV32I integer ops, drives the ALU and
// synthesises SLT/SLTU/SRA with extra passes. ALU_SEQ_BACK_TO_BACK_EN lets DONE accept directly.
module alu_op_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic            in_is_imm,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [6:0]      alu_sel,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam logic [6:0] SEL_ADD = 7'b0000001;
  localparam logic [6:0] SEL_SUB = 7'b0000010;
  localparam logic [6:0] SEL_XOR = 7'b0000100;
  localparam logic [6:0] SEL_OR  = 7'b0001000;
  localparam logic [6:0] SEL_AND = 7'b0010000;
  localparam logic [6:0] SEL_SHR = 7'b0100000;
  localparam logic [6:0] SEL_SHL = 7'b1000000;

  typedef enum logic [2:0] {IDLE, EXEC, PASS2, FIX, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SHL, OP_SLT, OP_SLTU, OP_XOR, OP_SHR, OP_SRA, OP_OR, OP_AND
  } op_t;

  function automatic op_t decode_op(input logic [2:0] f3, input logic f7, input logic imm);
    op_t op;
    case (f3)
      3'b000:  op = (f7 && !imm) ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SHL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = f7 ? OP_SRA : OP_SHR;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_illegal(input logic [2:0] f3, input logic f7, input logic imm);
    return (!imm && f7 && (f3 != 3'b000) && (f3 != 3'b101)) ||
           (imm && f7 && (f3 == 3'b001));
  endfunction

  // SLT/SLTU borrow the subtractor; SRA starts as a logical shift.
  function automatic logic [6:0] exec_sel(input op_t op);
    logic [6:0] s;
    case (op)
      OP_ADD:                s = SEL_ADD;
      OP_SUB, OP_SLT, OP_SLTU: s = SEL_SUB;
      OP_SHL:                s = SEL_SHL;
      OP_XOR:                s = SEL_XOR;
      OP_SHR, OP_SRA:        s = SEL_SHR;
      OP_OR:                 s = SEL_OR;
      default:               s = SEL_AND;
    endcase
    return s;
  endfunction

  state_t          state;
  op_t             op_q;
  logic [XLEN-1:0] a_q, b_q, tmp;
  logic            accept, retire, lt;
  op_t             dec_op;
  logic            dec_ill;

`ifdef ALU_SEQ_BACK_TO_BACK_EN
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
  assign in_ready = (state == IDLE);
`endif

  assign accept  = in_valid && in_ready;
  assign retire  = out_valid && out_ready;
  assign dec_op  = decode_op(in_funct3, in_funct7_5, in_is_imm);
  assign dec_ill = is_illegal(in_funct3, in_funct7_5, in_is_imm);

  // Operand signs decide when they differ; otherwise the sign of A-B does.
  always_comb begin
    lt = tmp[XLEN-1];
    if (a_q[XLEN-1] != b_q[XLEN-1])
      lt = (op_q == OP_SLTU) ? b_q[XLEN-1] : a_q[XLEN-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      tmp         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          tmp <= alu_result;
          if (op_q == OP_SRA) begin
            state   <= PASS2;
            alu_a   <= '1;
            alu_b   <= b_q;
            alu_sel <= SEL_SHR;
          end else begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            if (op_q == OP_SLT || op_q == OP_SLTU) begin
              state <= FIX;
            end else begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= alu_result;
            end
          end
        end
        PASS2: begin
          // Fill the vacated top bits: ~(all-ones >> sh) is exactly the sign mask.
          out_result <= tmp | (a_q[XLEN-1] ? ~alu_result : '0);
          out_valid  <= 1'b1;
          state      <= DONE;
          alu_a      <= '0;
          alu_b      <= '0;
          alu_sel    <= '0;
        end
        FIX: begin
          out_result <= {{(XLEN-1){1'b0}}, lt};
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (retire) begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            state       <= IDLE;
          end
        end
        default: ;
      endcase

      // A new request overrides the retire bookkeeping above when both happen together.
      if (accept) begin
        a_q  <= in_a;
        b_q  <= in_b;
        op_q <= dec_op;
        if (dec_ill) begin
          state       <= DONE;
          out_valid   <= 1'b1;
          out_result  <= '0;
          out_illegal <= 1'b1;
          alu_sel     <= '0;
        end else begin
          state       <= EXEC;
          out_valid   <= 1'b0;
          out_illegal <= 1'b0;
          alu_a       <= in_a;
          alu_b       <= in_b;
          alu_sel     <= exec_sel(dec_op);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural one-hot ALU attached.
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_funct7_5, in_is_imm;
  logic [2:0]  in_funct3;
  logic [31:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
  logic [6:0]  alu_sel;
  logic        out_valid, out_ready, out_illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_op_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_is_imm(in_is_imm),
    .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_sel)
      7'b0000001: alu_result = alu_a + alu_b;
      7'b0000010: alu_result = alu_a - alu_b;
      7'b0000100: alu_result = alu_a ^ alu_b;
      7'b0001000: alu_result = alu_a | alu_b;
      7'b0010000: alu_result = alu_a & alu_b;
      7'b0100000: alu_result = alu_a >> alu_b[4:0];
      7'b1000000: alu_result = alu_a << alu_b[4:0];
      default:    alu_result = 32'h0;
    endcase
  end

  // Drives one request and returns #1 after its accept edge; inputs are then scrambled.
  task automatic send(input logic [2:0] f3, input logic f7, input logic imm,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_funct3 = f3; in_funct7_5 = f7; in_is_imm = imm; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_funct3 = ~f3;
  endtask

  // Edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'b0; in_funct7_5 = 1'b0; in_is_imm = 1'b0; in_a = '0; in_b = '0;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0 || out_illegal !== 1'b0) begin n_err++; $display("FAIL reset_out got %h/%b want 0/0", out_result, out_illegal); end
    n_cmp++; if (alu_sel !== 7'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin n_err++; $display("FAIL reset_alu got %b %h %h want 0", alu_sel, alu_a, alu_b); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_arith();
    int lat;
    send(3'b000, 1'b0, 1'b0, 32'd5, 32'd3);
    n_cmp++; if (alu_sel !== 7'b0000001) begin n_err++; $display("FAIL add_sel got %b want 0000001", alu_sel); end
    n_cmp++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin n_err++; $display("FAIL add_operands got %h %h want 5 3", alu_a, alu_b); end
    wait_valid(lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL add_latency got %0d want 2", lat); end
    n_cmp++; if (out_result !== 32'd8 || out_illegal !== 1'b0) begin n_err++; $display("FAIL add_result got %h/%b want 8/0", out_result, out_illegal); end
    n_cmp++; if (alu_sel !== 7'h0) begin n_err++; $display("FAIL add_done_sel got %b want 0", alu_sel); end
    retire();
    send(3'b000, 1'b1, 1'b0, 32'd3, 32'd5);
    n_cmp++; if (alu_sel !== 7'b0000010) begin n_err++; $display("FAIL sub_sel got %b want 0000010", alu_sel); end
    wait_valid(lat);
    n_cmp++; if (lat !== 2 || out_result !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_result got %0d/%h want 2/fffffffe", lat, out_result); end
    retire();
    // OP-IMM with bit 30 set on funct3=000 is still ADDI
    send(3'b000, 1'b1, 1'b1, 32'd10, 32'hFFFF_FFFF);
    wait_valid(lat);
    n_cmp++; if (out_result !== 32'd9 || out_illegal !== 1'b0) begin n_err++; $display("FAIL addi_f7 got %h/%b want 9/0", out_result, out_illegal); end
    retire();
    send(3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0024);
    wait_valid(lat);
    n_cmp++; if (out_result !== 32'h0000_0030) begin n_err++; $display("FAIL slli got %h want 00000030", out_result); end
    retire();
    send(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4);
    n_cmp++; if (alu_sel !== 7'b0100000) begin n_err++; $display("FAIL srl_sel got %b want 0100000", alu_sel); end
    wait_valid(lat);
    n_cmp++; if (lat !== 2 || out_result !== 32'h0800_0000) begin n_err++; $display("FAIL srl got %0d/%h want 2/08000000", lat, out_result); end
    retire();
    send(3'b100, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    wait_valid(lat);
    n_cmp++; if (out_result !== 32'hFF00_EDCB) begin n_err++; $display("FAIL xor got %h want ff00edcb", out_result); end
    retire();
    send(3'b110, 1'b0, 1'b0, 32'hF0F0_0000, 32'h0000_00FF);
    wait_valid(lat);
    n_cmp++; if (out_result !== 32'hF0F0_00FF) begin n_err++; $display("FAIL or got %h want f0f000ff", out_result); end
    retire();
    send(3'b111, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    wait_valid(lat);
    n_cmp++; if (out_result !== 32'h00F0_1234) begin n_err++; $display("FAIL and got %h want 00f01234", out_result); end
    retire();
  endtask

  task automatic test_slt();
    int lat;
    send(3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    n_cmp++; if (alu_sel !== 7'b0000010) begin n_err++; $display("FAIL slt_sel got %b want 0000010", alu_sel); end
    wait_valid(lat);
    n_cmp++; if (lat !== 3 || out_result !== 32'd1) begin n_err++; $display("FAIL slt_neg got %0d/%h want 3/1", lat, out_result); end
    retire();
    send(3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_valid(lat);
    n_cmp++; if (lat !== 3 || out_result !== 32'd0) begin n_err++; $display("FAIL sltu_big got %0d/%h want 3/0", lat, out_result); end
    retire();
    send(3'b011, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF);
    wait_valid(lat);
    n_cmp++; if (out_result !== 32'd1) begin n_err++; $display("FAIL sltiu_small got %h want 1", out_result); end
    retire();
    send(3'b010, 1'b0, 1'b0, 32'd3, 32'd5);
    wait_valid(lat);
    n_cmp++; if (out_result !== 32'd1) begin n_err++; $display("FAIL slt_same_sign got %h want 1", out_result); end
    retire();
    send(3'b010, 1'b0, 1'b0, 32'd5, 32'd5);
    wait_valid(lat);
    n_cmp++; if (out_result !== 32'd0) begin n_err++; $display("FAIL slt_equal got %h want 0", out_result); end
    retire();
  endtask

  task automatic test_sra();
    int lat;
    send(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
    n_cmp++; if (alu_sel !== 7'b0100000) begin n_err++; $display("FAIL sra_exec_sel got %b want 0100000", alu_sel); end
    @(posedge clk); #1;
    n_cmp++; if (alu_sel !== 7'b0100000 || alu_a !== 32'hFFFF_FFFF || alu_b !== 32'd4) begin n_err++; $display("FAIL sra_pass2 got %b %h %h want 0100000 ffffffff 4", alu_sel, alu_a, alu_b); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'hF800_0000) begin n_err++; $display("FAIL sra_result got %b/%h want 1/f8000000", out_valid, out_result); end
    retire();
    // SRAI of a positive value; immediate carries bit 10 (funct7_5) above the shamt
    send(3'b101, 1'b1, 1'b1, 32'h7000_0000, 32'h0000_0404);
    wait_valid(lat);
    n_cmp++; if (lat !== 3 || out_result !== 32'h0700_0000 || out_illegal !== 1'b0) begin n_err++; $display("FAIL srai_pos got %0d/%h/%b want 3/07000000/0", lat, out_result, out_illegal); end
    retire();
  endtask

  task automatic test_illegal();
    int lat;
    send(3'b100, 1'b1, 1'b0, 32'd7, 32'd9);
    n_cmp++; if (alu_sel !== 7'h0) begin n_err++; $display("FAIL illegal_sel got %b want 0", alu_sel); end
    wait_valid(lat);
    n_cmp++; if (lat !== 1 || out_illegal !== 1'b1 || out_result !== 32'h0) begin n_err++; $display("FAIL illegal_op got %0d/%b/%h want 1/1/0", lat, out_illegal, out_result); end
    retire();
    n_cmp++; if (out_illegal !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_clear got %b/%b/%b want 0/0/1", out_illegal, out_valid, in_ready); end
    send(3'b001, 1'b1, 1'b1, 32'd7, 32'd9);
    n_cmp++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin n_err++; $display("FAIL illegal_slli got %b/%b want 1/1", out_valid, out_illegal); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    send(3'b000, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222);
    wait_valid(lat);
    in_funct3 = 3'b000; in_funct7_5 = 1'b0; in_is_imm = 1'b0; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h3333_3333 || in_ready !== 1'b0) begin n_err++; $display("FAIL backpressure_hold[%0d] got %b/%h/%b want 1/33333333/0", i, out_valid, out_result, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    retire();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL backpressure_release got %b/%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    send(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_sel !== 7'h0) begin n_err++; $display("FAIL reset_mid got %b/%b/%b want 0/1/0", out_valid, in_ready, alu_sel); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0 || alu_a !== 32'h0) begin n_err++; $display("FAIL reset_mid_hold got %b/%h want 0/0", out_valid, alu_a); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(3'b000, 1'b0, 1'b0, 32'd1, 32'd2);
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd3) begin n_err++; $display("FAIL b2b_first got %b/%h want 1/3", out_valid, out_result); end
    in_funct3 = 3'b000; in_funct7_5 = 1'b0; in_is_imm = 1'b0; in_a = 32'd4; in_b = 32'd5; in_valid = 1'b1;
`ifdef ALU_SEQ_BACK_TO_BACK_EN
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || alu_sel !== 7'b0000001 || alu_a !== 32'd4) begin n_err++; $display("FAIL b2b_exec got %b/%b/%h want 0/0000001/4", out_valid, alu_sel, alu_a); end
`else
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_bubble got %b/%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (alu_sel !== 7'b0000001 || alu_a !== 32'd4) begin n_err++; $display("FAIL b2b_exec got %b/%h want 0000001/4", alu_sel, alu_a); end
`endif
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd9) begin n_err++; $display("FAIL b2b_second got %b/%h want 1/9", out_valid, out_result); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle got %b/%b want 0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_slt();
    test_sra();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
